// File: rtl/pwm_out_if.sv
// Sample-in / PWM-out bundle of the pwm_out stage; the generator side drives
// val/val_ld, the output stage returns the complementary pair, sync and duty.
interface pwm_out_if;
    logic [7:0] val;
    logic       val_ld;
    logic       pwm_p;
    logic       pwm_n;
    logic       sync;
    logic [7:0] duty_q;

    modport master (
        output val,
        output val_ld,
        input  pwm_p,
        input  pwm_n,
        input  sync,
        input  duty_q
    );

    modport slave (
        input  val,
        input  val_ld,
        output pwm_p,
        output pwm_n,
        output sync,
        output duty_q
    );
endinterface

// File: rtl/pwm_out.sv
// Double-buffered 8-bit PWM output stage with complementary outputs, dead-time
// insertion and a once-per-period sync pulse for pacing upstream generators.
module pwm_out #(
    parameter int PRE  = 4,
    parameter int DEAD = 2
) (
    input  logic      clk,
    input  logic      rst,
    pwm_out_if.slave  bus
);

    localparam int PW = (PRE > 1) ? $clog2(PRE) : 1;
    localparam int DW = (DEAD > 1) ? $clog2(DEAD) : 1;
    localparam logic [PW-1:0] PCNT_MAX = PW'(PRE - 1);
    localparam logic [DW-1:0] DTC_INIT = DW'(DEAD - 1);

    typedef enum logic [1:0] {
        N_ON  = 2'd0,
        DT_NP = 2'd1,
        P_ON  = 2'd2,
        DT_PN = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [DW-1:0] dtc_r;
    logic [DW-1:0] dtc_s;
    logic [PW-1:0] pcnt_r;
    logic [7:0]    cnt_r;
    logic [7:0]    duty_r;
    logic [7:0]    shadow_r;
    logic          pending_r;
    logic          tick_s;
    logic          wrap_s;
    logic          raw_s;

    assign tick_s = (pcnt_r == PCNT_MAX);
    assign wrap_s = tick_s && (cnt_r == 8'd255);
    assign raw_s  = (cnt_r < duty_r);

    assign bus.pwm_p  = (state_r == P_ON);
    assign bus.pwm_n  = (state_r == N_ON);
    assign bus.sync   = (pcnt_r == '0) && (cnt_r == 8'd0);
    assign bus.duty_q = duty_r;

    // Prescaler, period counter and the shadow/active duty double-buffer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pcnt_r    <= '0;
            cnt_r     <= 8'd0;
            duty_r    <= 8'd0;
            shadow_r  <= 8'd0;
            pending_r <= 1'b0;
        end else begin
            pcnt_r <= tick_s ? '0 : (pcnt_r + PW'(1));
            if (tick_s) begin
                cnt_r <= cnt_r + 8'd1;
            end
            // A load landing exactly on the wrap bypasses the shadow so it is
            // not lost and not applied a second time one period later.
            if (wrap_s) begin
                if (bus.val_ld) begin
                    duty_r    <= bus.val;
                    shadow_r  <= bus.val;
                    pending_r <= 1'b0;
                end else if (pending_r) begin
                    duty_r    <= shadow_r;
                    pending_r <= 1'b0;
                end
            end else if (bus.val_ld) begin
                shadow_r  <= bus.val;
                pending_r <= 1'b1;
            end
        end
    end

    // Dead-time FSM state and dead-time down-counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= DT_PN;
            dtc_r   <= DTC_INIT;
        end else begin
            state_r <= state_s;
            dtc_r   <= dtc_s;
        end
    end

    // Dead-time next-state logic; raw glitches inside a dead window do not
    // restart the counter, and the side chosen at its end follows raw then.
    always_comb begin
        state_s = state_r;
        dtc_s   = dtc_r;
        case (state_r)
            N_ON: begin
                if (raw_s) begin
                    state_s = DT_NP;
                    dtc_s   = DTC_INIT;
                end else begin
                    state_s = N_ON;
                end
            end
            DT_NP: begin
                if (dtc_r != '0) begin
                    dtc_s = dtc_r - DW'(1);
                end else if (raw_s) begin
                    state_s = P_ON;
                end else begin
                    state_s = N_ON;
                end
            end
            P_ON: begin
                if (!raw_s) begin
                    state_s = DT_PN;
                    dtc_s   = DTC_INIT;
                end else begin
                    state_s = P_ON;
                end
            end
            DT_PN: begin
                if (dtc_r != '0) begin
                    dtc_s = dtc_r - DW'(1);
                end else if (!raw_s) begin
                    state_s = N_ON;
                end else begin
                    state_s = P_ON;
                end
            end
            default: begin
                state_s = DT_PN;
                dtc_s   = DTC_INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_pwm_out.sv
// Scoreboard bench for pwm_out: per-period duty/high-time expectations are
// queued by the stimulus and checked by an independent per-cycle monitor.
module tb_pwm_out;

    localparam int PRE   = 4;
    localparam int DEAD  = 2;
    localparam int DEAD5 = 5;
    localparam int PER   = 256 * PRE;

    typedef struct {
        int duty;
        int p;
        int n;
    } exp_t;

    logic clk  = 1'b0;
    logic rst  = 1'b0;
    logic rst5 = 1'b0;

    pwm_out_if bus ();
    pwm_out_if bus5 ();

    pwm_out #(.PRE(PRE), .DEAD(DEAD))  u_dut  (.clk(clk), .rst(rst),  .bus(bus));
    pwm_out #(.PRE(PRE), .DEAD(DEAD5)) u_dut5 (.clk(clk), .rst(rst5), .bus(bus5));

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    exp_t       q[$];
    exp_t       rst_exp;
    int         m_duty = 0;
    bit         ld_en  [PER];
    logic [7:0] ld_val [PER];
    bit         done5 = 1'b0;

    function automatic void chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endfunction

    // Expected per-period figures straight from the duty/dead-time arithmetic.
    function automatic exp_t model(input int d, input int dead, input bit first);
        exp_t e;
        e.duty = d;
        if (d == 0) begin
            e.p = 0;
            e.n = PER;
        end else if (d * PRE <= dead) begin
            e.p = 0;
            e.n = PER - dead;
        end else begin
            e.p = d * PRE - dead;
            e.n = (256 - d) * PRE - dead;
        end
        if (first) e.n = e.n - dead;
        return e;
    endfunction

    function automatic void clear_loads();
        for (int i = 0; i < PER; i++) begin
            ld_en[i]  = 1'b0;
            ld_val[i] = 8'd0;
        end
    endfunction

    function automatic void ld(input int pos, input logic [7:0] v);
        ld_en[pos]  = 1'b1;
        ld_val[pos] = v;
    endfunction

    task automatic do_reset(input int ncyc);
        @(negedge clk);
        rst        = 1'b0;
        bus.val_ld = 1'b0;
        q.delete();
        m_duty = 0;
        repeat (ncyc) @(posedge clk);
    endtask

    // One period of stimulus; cut >= 0 asserts reset at that position instead.
    task automatic run_period(input int cut);
        int   nd;
        exp_t e;
        nd = m_duty;
        for (int i = 0; i < PER; i++) begin
            if (ld_en[i]) nd = int'(ld_val[i]);
        end
        if (cut < 0) begin
            e = model(nd, DEAD, 1'b0);
            q.push_back(e);
            m_duty = nd;
        end
        for (int pos = 0; pos < PER; pos++) begin
            @(negedge clk);
            if (pos == cut) begin
                rst        = 1'b0;
                bus.val_ld = 1'b0;
                q.delete();
                m_duty = 0;
                @(posedge clk);
                break;
            end
            rst        = 1'b1;
            bus.val_ld = ld_en[pos];
            bus.val    = ld_en[pos] ? ld_val[pos] : 8'($urandom);
        end
        clear_loads();
    endtask

    initial begin : monitor
        exp_t cur;
        int   pos;
        int   pc;
        int   nc;
        bit   have;
        have = 1'b0;
        pos  = 0;
        pc   = 0;
        nc   = 0;
        cur  = rst_exp;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                chk("rst_pwm_p", int'(bus.pwm_p), 0);
                chk("rst_pwm_n", int'(bus.pwm_n), 0);
                chk("rst_duty_q", int'(bus.duty_q), 0);
                chk("rst_sync", int'(bus.sync), 1);
                cur  = rst_exp;
                have = 1'b1;
                pos  = 0;
                pc   = 0;
                nc   = 0;
            end else if (have) begin
                pos = (pos + 1) % PER;
                if (pos == 0) begin
                    chk("pwm_p_high", pc, cur.p);
                    chk("pwm_n_high", nc, cur.n);
                    pc = 0;
                    nc = 0;
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL scoreboard_empty: got 0 entries expected 1 at %0t", $time);
                        have = 1'b0;
                    end else begin
                        cur = q.pop_front();
                    end
                end
                chk("sync", int'(bus.sync), (pos == 0) ? 1 : 0);
                chk("duty_q", int'(bus.duty_q), cur.duty);
                chk("overlap", int'(bus.pwm_p & bus.pwm_n), 0);
            end
            if (have) begin
                pc += int'(bus.pwm_p);
                nc += int'(bus.pwm_n);
            end
        end
    end

    // Second instance with a dead time longer than a one-count pulse.
    initial begin : dead5_check
        exp_t e5;
        int   d5;
        int   pc;
        int   nc;
        int   nxt;
        bus5.val    = 8'd0;
        bus5.val_ld = 1'b0;
        @(negedge clk);
        rst5 = 1'b0;
        repeat (2) @(posedge clk);
        d5 = 0;
        for (int k = 0; k < 3; k++) begin
            pc  = 0;
            nc  = 0;
            e5  = model(d5, DEAD5, k == 0);
            nxt = (k == 0) ? 1 : 100;
            for (int pos = 0; pos < PER; pos++) begin
                #1;
                if (pos == 0) begin
                    chk("d5_duty_q", int'(bus5.duty_q), e5.duty);
                    chk("d5_sync", int'(bus5.sync), 1);
                end
                pc += int'(bus5.pwm_p);
                nc += int'(bus5.pwm_n);
                @(negedge clk);
                rst5        = 1'b1;
                bus5.val_ld = (pos == 10) && (k < 2);
                bus5.val    = (pos == 10) ? 8'(nxt) : 8'($urandom);
                @(posedge clk);
            end
            chk("d5_pwm_p_high", pc, e5.p);
            chk("d5_pwm_n_high", nc, e5.n);
            if (k < 2) d5 = nxt;
        end
        done5 = 1'b1;
    end

    initial begin : stimulus
        bus.val    = 8'd0;
        bus.val_ld = 1'b0;
        rst        = 1'b0;
        rst_exp    = model(0, DEAD, 1'b1);
        clear_loads();
        do_reset(3);

        run_period(-1);
        run_period(-1);

        ld(400, 8'h80);
        run_period(-1);
        run_period(-1);
        run_period(-1);

        ld(100, 8'h10);
        ld(700, 8'h40);
        run_period(-1);
        run_period(-1);

        ld(50, 8'h10);
        ld(PER - 1, 8'h20);
        run_period(-1);
        run_period(-1);
        run_period(-1);

        ld(10, 8'hFF);
        run_period(-1);
        ld(10, 8'h01);
        run_period(-1);
        ld(10, 8'h00);
        run_period(-1);

        for (int k = 0; k < 6; k++) begin
            int nl;
            nl = $urandom_range(0, 3);
            for (int j = 0; j < nl; j++) ld($urandom_range(0, PER - 2), 8'($urandom));
            if ($urandom_range(0, 2) == 0) ld(PER - 1, 8'($urandom));
            run_period(-1);
        end

        ld(5, 8'h80);
        run_period(-1);
        run_period(300);
        run_period(-1);
        run_period(-1);

        bus.val_ld = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        if (!done5) begin
            total++;
            bad++;
            $display("FAIL dead5_done: got 0 expected 1");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
